hist_stream_out: RTL and testbench
==================================

// Module: hist_stream_out
// PURPOSE
//  Downstream readout stage for the histogram engine. After the histogram block pulses done, this block
//  reads the finished frame from the output RAM read port, one byte per address, in raster order.
//  It emits each pixel as a valid/ready byte stream with frame and line markers, for a DMA/UART/video sink.
//  A 2-entry buffer absorbs the 1-cycle BRAM read latency, so throughput is 1 pixel/clk under backpressure.
// PARAMETERS
//  W               64             frame width in pixels
//  H               64             frame height in pixels
//  TOTAL_PIXEL     W*H            pixels per frame
//  TOTAL_PIXEL_BIT $clog2(W*H)    RAM address width
// PORTS
//  clk      in   1                single clock; all logic rising-edge
//  rst      in   1                asynchronous, active-high reset
//  start    in   1                begin readout; connect to histogram done pulse
//  busy     out  1                high from accepted start until done
//  done     out  1                1-clk pulse after the last pixel handshake
//  rd_addr  out  TOTAL_PIXEL_BIT  output-RAM read address
//  rd_data  in   8                output-RAM data; valid 1 clk after rd_addr (sync read)
//  m_valid  out  1                stream beat valid
//  m_ready  in   1                sink accepts beat; a transfer happens when m_valid && m_ready
//  m_data   out  8                pixel value
//  m_sof    out  1                beat is pixel 0
//  m_eol    out  1                beat is last pixel of a row (x == W-1)
//  m_last   out  1                beat is pixel TOTAL_PIXEL-1
// BEHAVIOUR
//  Reset values: busy=0, done=0, rd_addr=0, m_valid=0, m_data=0, m_sof=m_eol=m_last=0.
//    FIFO is empty, counters are 0, FSM is IDLE.
//  FSM states:
//    IDLE: start=1 -> RUN. Clear the issue address and x counter.
//    RUN: issue reads while credit allows. After issuing address TOTAL_PIXEL-1 -> DRAIN.
//    DRAIN: no new reads. When the m_last beat transfers -> DONE.
//    DONE: done=1 for one clk -> IDLE.
//  start is ignored unless the FSM is IDLE. Re-start in the DONE cycle is ignored.
//  Issue rule: a read is issued in a cycle when (fifo_count + inflight - pop) < 2.
//    pop = m_valid && m_ready in that cycle. inflight is at most 1.
//    rd_addr increments by 1 per issue. rd_addr holds its value when no read is issued.
//  Each read carries sof/eol/last tags, computed from the issued address and x counter.
//    The tags are delayed 1 clk together with the data and written into the FIFO entry.
//    x wraps from W-1 to 0.
//  Latency: start is sampled at edge E0. rd_addr=0 is driven after E0. Data is captured at E2.
//    m_valid rises after E2 (2 clk). With m_ready held high, beats are back-to-back.
//    The frame takes TOTAL_PIXEL+2 clks from start to the last beat; done follows 1 clk later.
//  Stream rules:
//    While m_valid=1 and m_ready=0, m_data and all tags stay stable.
//    m_valid never drops without a transfer.
//  FIFO: 2 entries. Push and pop in the same cycle are allowed, including when full.
//    Overflow is impossible by the issue rule. A bench assertion must flag any overflow.
//  Edge cases:
//    W=1: every beat has m_eol=1.
//    TOTAL_PIXEL=1: the single beat has sof=eol=last=1.
//    m_ready low for N clks: at most 2 beats are buffered and issue stalls, with no loss or duplication.
//    rst mid-frame: the stream aborts immediately. All outputs go to their reset values and the FIFO is flushed.
//      No done pulse is produced. The next start replays from pixel 0.
// STRUCTURE
//  hist_pkg.vh holds:
//    the state encodings IDLE/RUN/DRAIN/DONE;
//    the FIFO depth localparam (2);
//    the default W/H shared with the histogram top.
//  Sub-module stream_skid_fifo: 2-entry, 11-bit wide ({last,eol,sof,data}), with count output.
//  Top-level integration: rd_addr/rd_data connect to the ram_out read port, and start connects to the histogram done.
// TESTING
//  Use W=4, H=2 and a RAM preloaded with mem[i]=i+16.
//  1. m_ready=1; start pulse ->
//     - 8 beats, data 16..23, back-to-back;
//     - sof on beat 0, eol on beats 3 and 7, last on beat 7;
//     - first m_valid 2 clk after start; done 1 clk after beat 7.
//  2. m_ready toggles 1,0,0,1,... (random 50%) ->
//     - the same 8 values in order, with none dropped or duplicated;
//     - data/tags stable while stalled.
//  3. m_ready=0 for 20 clks after start ->
//     - m_valid=1 with data 16 held;
//     - rd_addr stalls at most 2 ahead of the last consumed pixel;
//     - after release, the remaining values stream out correctly.
//  4. Second start while busy (mid-frame) -> ignored; exactly 8 beats and 1 done pulse occur.
//  5. rst asserted after beat 3 ->
//     - outputs go to reset values immediately; no done;
//     - a new start yields beats 16..23 again with sof on 16.
//  6. W=1, H=1 with mem[0]=0xA5 -> a single beat 0xA5 with sof=eol=last=1, then done.

Source files
------------

// File: rtl/hist_stream_out_pkg.sv
// Shared types and constants for the histogram readout stage.
// Frame defaults match the histogram top so both sides agree on addressing.
package hist_stream_out_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    localparam int unsigned FifoDepth = 2;
    localparam int unsigned DefaultW  = 64;
    localparam int unsigned DefaultH  = 64;
    localparam int unsigned BeatBits  = 11;

    typedef struct packed {
        logic       last;
        logic       eol;
        logic       sof;
        logic [7:0] data;
    } beat_t;

    // A one-pixel frame still needs a 1-bit address bus.
    function automatic int unsigned addr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hist_stream_out_skid_fifo.sv
// Two-entry beat buffer that soaks up the RAM read latency under backpressure.
// Simultaneous push and pop is legal even when full; the popped slot is reused.
module hist_stream_out_skid_fifo
    import hist_stream_out_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [BeatBits-1:0] wdata,
    input  logic                pop,
    output logic [BeatBits-1:0] rdata,
    output logic [1:0]          count
);

    logic [BeatBits-1:0] mem [FifoDepth];
    logic                wr_ptr;
    logic                rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem    <= '{default: '0};
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/hist_stream_out.sv
// Reads a finished histogram frame from the output RAM in raster order and
// emits it as a valid/ready byte stream with sof/eol/last markers.
module hist_stream_out
    import hist_stream_out_pkg::*;
#(
    parameter int unsigned W               = DefaultW,
    parameter int unsigned H               = DefaultH,
    parameter int unsigned TOTAL_PIXEL     = W * H,
    parameter int unsigned TOTAL_PIXEL_BIT = addr_width(TOTAL_PIXEL)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [TOTAL_PIXEL_BIT-1:0] rd_addr,
    input  logic [7:0]                 rd_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [7:0]                 m_data,
    output logic                       m_sof,
    output logic                       m_eol,
    output logic                       m_last
);

    localparam logic [TOTAL_PIXEL_BIT-1:0] LastAddr = TOTAL_PIXEL_BIT'(TOTAL_PIXEL - 1);
    localparam logic [TOTAL_PIXEL_BIT-1:0] LastX    = TOTAL_PIXEL_BIT'(W - 1);
    localparam logic [TOTAL_PIXEL_BIT-1:0] One      = TOTAL_PIXEL_BIT'(1);

    state_e                     state_q;
    state_e                     state_d;
    logic [TOTAL_PIXEL_BIT-1:0] addr_d;
    logic [TOTAL_PIXEL_BIT-1:0] x_q;
    logic [TOTAL_PIXEL_BIT-1:0] x_d;
    logic                       inflight_q;
    logic [2:0]                 tag_q;
    logic                       issue;
    logic                       pop;
    logic                       room;
    logic [2:0]                 occupancy;
    logic [1:0]                 fifo_count;
    logic [BeatBits-1:0]        head;
    beat_t                      head_beat;

    assign pop = m_valid && m_ready;

    // Buffered plus in-flight beats, net of this cycle's pop, must stay below two.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign room      = occupancy < 3'd2;

    always_comb begin
        state_d = state_q;
        addr_d  = rd_addr;
        x_d     = x_q;
        issue   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    addr_d  = '0;
                    x_d     = '0;
                end
            end
            StRun: begin
                if (room) begin
                    issue = 1'b1;
                    if (rd_addr == LastAddr) begin
                        state_d = StDrain;
                    end else begin
                        addr_d = rd_addr + One;
                        x_d    = (x_q == LastX) ? '0 : x_q + One;
                    end
                end
            end
            StDrain: begin
                if (pop && m_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            rd_addr    <= '0;
            x_q        <= '0;
            inflight_q <= 1'b0;
            tag_q      <= 3'b000;
        end else begin
            state_q    <= state_d;
            rd_addr    <= addr_d;
            x_q        <= x_d;
            inflight_q <= issue;
            // Tags ride alongside the read so they land in the FIFO with its data.
            if (issue) begin
                tag_q <= {rd_addr == LastAddr, x_q == LastX, rd_addr == '0};
            end
        end
    end

    hist_stream_out_skid_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .wdata ({tag_q, rd_data}),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count)
    );

    assign head_beat = beat_t'(head);

    assign m_valid = fifo_count != 2'd0;
    assign m_data  = m_valid ? head_beat.data : 8'd0;
    assign m_sof   = m_valid && head_beat.sof;
    assign m_eol   = m_valid && head_beat.eol;
    assign m_last  = m_valid && head_beat.last;

    assign busy = (state_q == StRun) || (state_q == StDrain);
    assign done = state_q == StDone;

endmodule

// File: tb/tb_hist_stream_out.sv
// Directed bench for hist_stream_out: a 4x2 frame with mem[i]=i+16 and a 1x1 frame with 0xA5.
module tb_hist_stream_out;

    typedef struct {
        logic [7:0] data;
        logic       sof;
        logic       eol;
        logic       last;
        int         cyc;
    } beat_rec_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_sof;
    logic       m_eol;
    logic       m_last;

    logic       start1;
    logic       busy1;
    logic       done1;
    logic [0:0] rd_addr1;
    logic [7:0] rd_data1;
    logic       m_valid1;
    logic       m_ready1;
    logic [7:0] m_data1;
    logic       m_sof1;
    logic       m_eol1;
    logic       m_last1;

    logic [7:0] mem  [8];
    logic [7:0] mem1 [2];

    int        n_tests = 0;
    int        n_fail  = 0;
    int        cyc     = 0;
    int        done_cnt = 0;
    int        done_cyc = 0;
    bit        prev_stall = 0;
    logic [10:0] prev_beat = '0;
    beat_rec_t beats[$];

    hist_stream_out #(
        .W (4),
        .H (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_sof   (m_sof),
        .m_eol   (m_eol),
        .m_last  (m_last)
    );

    hist_stream_out #(
        .W (1),
        .H (1)
    ) dut1 (
        .clk     (clk),
        .rst     (rst),
        .start   (start1),
        .busy    (busy1),
        .done    (done1),
        .rd_addr (rd_addr1),
        .rd_data (rd_data1),
        .m_valid (m_valid1),
        .m_ready (m_ready1),
        .m_data  (m_data1),
        .m_sof   (m_sof1),
        .m_eol   (m_eol1),
        .m_last  (m_last1)
    );

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'(i + 16);
        mem1[0] = 8'hA5;
        mem1[1] = 8'h00;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_data  <= mem[rd_addr];
        rd_data1 <= mem1[rd_addr1];
        cyc      <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Handshakes observed here complete on the following rising edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(m_valid), 1);
                check("hold_beat", 32'({m_last, m_eol, m_sof, m_data}), 32'(prev_beat));
            end
            prev_stall = m_valid && !m_ready;
            prev_beat  = {m_last, m_eol, m_sof, m_data};
            if (m_valid && m_ready) beats.push_back('{m_data, m_sof, m_eol, m_last, cyc});
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (dut.u_fifo.push && !dut.u_fifo.pop)
                check("fifo_ovf", 32'(dut.u_fifo.count == 2'd2), 0);
        end
    end

    task automatic check_frame(input string tag);
        check({tag, "_count"}, beats.size(), 8);
        foreach (beats[j]) begin
            check({tag, "_data"}, 32'(beats[j].data), 16 + j);
            check({tag, "_tags"}, 32'({beats[j].sof, beats[j].eol, beats[j].last}),
                  32'({j == 0, j % 4 == 3, j == 7}));
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_rd_addr"}, 32'(rd_addr), 0);
        check({tag, "_valid"}, 32'(m_valid), 0);
        check({tag, "_data"}, 32'(m_data), 0);
        check({tag, "_tags"}, 32'({m_sof, m_eol, m_last}), 0);
    endtask

    // mode 0: ready high; 1: random ready; 2: ready low for `stall` cycles after start.
    task automatic run_frame(input string tag, input int mode, input int stall,
                             input int restart_at, input bit dc_restart, input int rst_after);
        int d0;
        int start_cyc;
        int first_v;
        bit finished;
        bit aborted;
        d0       = done_cnt;
        first_v  = -1;
        finished = 1'b0;
        aborted  = 1'b0;
        beats.delete();
        @(posedge clk); #1;
        start   = 1'b1;
        m_ready = (mode == 2) ? 1'b0 : 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        start_cyc = cyc;
        for (int i = 0; i < 300 && !finished && !aborted; i++) begin
            @(negedge clk); #1;
            if (first_v < 0 && m_valid) first_v = cyc;
            if (i == 0) check({tag, "_busy"}, 32'(busy), 1);
            if (mode == 2 && i < stall)
                check({tag, "_ahead"}, 32'((int'(rd_addr) - beats.size()) <= 2), 1);
            if (mode == 2 && i == stall - 1) begin
                check({tag, "_held_valid"}, 32'(m_valid), 1);
                check({tag, "_held_data"}, 32'(m_data), 16);
                check({tag, "_held_addr"}, 32'(rd_addr), 2);
            end
            if (done_cnt != d0) begin
                finished = 1'b1;
            end else if (rst_after > 0 && beats.size() >= rst_after) begin
                aborted = 1'b1;
            end else begin
                @(posedge clk); #1;
                case (mode)
                    1:       m_ready = 1'($urandom_range(0, 1));
                    2:       m_ready = (i >= stall);
                    default: m_ready = 1'b1;
                endcase
                start = (i == restart_at);
            end
        end
        if (aborted) begin
            @(posedge clk); #1;
            rst   = 1'b1;
            start = 1'b0;
            #1;
            check_reset_outs({tag, "_abort"});
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            repeat (15) @(posedge clk);
            #1;
            check({tag, "_no_done"}, done_cnt - d0, 0);
            check({tag, "_beats_before_rst"}, beats.size(), rst_after);
        end else begin
            if (finished && dc_restart) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            repeat (15) @(posedge clk);
            #1;
            check({tag, "_done_once"}, done_cnt - d0, 1);
            if (mode == 0 && beats.size() == 8) begin
                check({tag, "_first_valid"}, first_v - start_cyc, 2);
                for (int j = 1; j < 8; j++)
                    check({tag, "_b2b"}, beats[j].cyc - beats[0].cyc, j);
                check({tag, "_done_lat"}, done_cyc - beats[7].cyc, 1);
            end
            check_frame(tag);
        end
    endtask

    initial begin
        int  n1;
        bit  got_done;
        rst      = 1'b1;
        start    = 1'b0;
        m_ready  = 1'b0;
        start1   = 1'b0;
        m_ready1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("rst");
        rst = 1'b0;

        run_frame("t1_basic",   0, 0,  -1, 1'b0, 0);
        run_frame("t2_random",  1, 0,  -1, 1'b0, 0);
        run_frame("t3_stall",   2, 20, -1, 1'b0, 0);
        run_frame("t4_restart", 0, 0,  3,  1'b1, 0);
        run_frame("t5_rst",     0, 0,  -1, 1'b0, 4);
        run_frame("t5_replay",  0, 0,  -1, 1'b0, 0);

        @(posedge clk); #1;
        start1   = 1'b1;
        m_ready1 = 1'b1;
        @(posedge clk); #1;
        start1   = 1'b0;
        n1       = 0;
        got_done = 1'b0;
        for (int i = 0; i < 20 && !got_done; i++) begin
            @(negedge clk); #1;
            if (m_valid1 && m_ready1) begin
                n1++;
                check("w1_data", 32'(m_data1), 32'h0000_00A5);
                check("w1_tags", 32'({m_sof1, m_eol1, m_last1}), 7);
            end
            if (done1) begin
                got_done = 1'b1;
                check("w1_done_after_beat", n1, 1);
            end
        end
        check("w1_beats", n1, 1);
        check("w1_done", 32'(got_done), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
